// File: rtl/peripheral_bus_responder_if.sv
// CPU data-bus view of the device region: strobes, address, write data, combinational read data.
interface peripheral_bus_responder_if;
  logic        Device_Read;
  logic        Device_Write;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;

  modport master (
    output Device_Read,
    output Device_Write,
    output MemBus_Address,
    output MemBus_Write_Data,
    input  Device_Read_Data
  );

  modport slave (
    input  Device_Read,
    input  Device_Write,
    input  MemBus_Address,
    input  MemBus_Write_Data,
    output Device_Read_Data
  );
endinterface

// File: rtl/peripheral_bus_responder.sv
// Device responder for the 0x4000_0000 region: timer with irq, LED/7-seg registers,
// systick counter and a byte UART transmitter. Reads are combinational, writes commit on clk.
module peripheral_bus_responder #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                          clk,
  input  logic                          reset,
  peripheral_bus_responder_if.slave     bus,
  output logic [7:0]                    leds,
  output logic [11:0]                   digi,
  output logic                          uart_tx,
  output logic                          irq
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  localparam logic [29:0] AddrTh      = 30'h1000_0000;
  localparam logic [29:0] AddrTl      = 30'h1000_0001;
  localparam logic [29:0] AddrTcon    = 30'h1000_0002;
  localparam logic [29:0] AddrLed     = 30'h1000_0003;
  localparam logic [29:0] AddrDigi    = 30'h1000_0004;
  localparam logic [29:0] AddrSystick = 30'h1000_0005;
  localparam logic [29:0] AddrTxd     = 30'h1000_0006;
  localparam logic [29:0] AddrUcon    = 30'h1000_0007;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  logic [29:0] word;
  logic [31:0] wdata;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd, wr_ucon;

  logic [31:0] th_q, th_d, tl_q, tl_d, systick_q;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  leds_q;
  logic [11:0] digi_q;
  logic        overflow, ovf_set;

  uart_state_e      state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             busy, baud_tc, frame_end;

  logic unused_addr;
  assign unused_addr = ^bus.MemBus_Address[1:0];

  assign word  = bus.MemBus_Address[31:2];
  assign wdata = bus.MemBus_Write_Data;

  assign wr_th   = bus.Device_Write && (word == AddrTh);
  assign wr_tl   = bus.Device_Write && (word == AddrTl);
  assign wr_tcon = bus.Device_Write && (word == AddrTcon);
  assign wr_led  = bus.Device_Write && (word == AddrLed);
  assign wr_digi = bus.Device_Write && (word == AddrDigi);
  assign wr_txd  = bus.Device_Write && (word == AddrTxd);
  assign wr_ucon = bus.Device_Write && (word == AddrUcon);

  // Timer: CPU writes to TH/TL override the hardware update; the overflow set of the
  // int-status bit is OR-ed in so a simultaneous TCON write never loses an interrupt.
  assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set  = overflow && tcon_q[1];

  always_comb begin
    th_d   = wr_th ? wdata : th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[0]) begin
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end
    if (wr_tl) begin
      tl_d = wdata;
    end
    if (wr_tcon) begin
      tcon_d = {wdata[2] | ovf_set, wdata[1:0]};
    end else begin
      tcon_d[2] = tcon_q[2] | ovf_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      leds_q    <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_q + 32'd1;
      if (wr_led) begin
        leds_q <= wdata[7:0];
      end
      if (wr_digi) begin
        digi_q <= wdata[11:0];
      end
    end
  end

  assign leds = leds_q;
  assign digi = digi_q;
  assign irq  = tcon_q[2];

  // UART transmitter
  assign busy    = (state_q != StIdle);
  assign baud_tc = (baud_q == BaudLast);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BaudW'(1);
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    frame_end = 1'b0;
    uart_tx   = 1'b1;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (wr_txd) begin
          data_d  = wdata[7:0];
          state_d = StStart;
        end
      end
      StStart: begin
        uart_tx = 1'b0;
        if (baud_tc) begin
          state_d   = StData;
          baud_d    = '0;
          bit_idx_d = '0;
        end
      end
      StData: begin
        uart_tx = data_q[bit_idx_q];
        if (baud_tc) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (baud_tc) begin
          state_d   = StIdle;
          baud_d    = '0;
          frame_end = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
      end
    endcase
  end

  // A frame end in the same cycle as a software clear leaves done set.
  always_comb begin
    done_d = done_q;
    if (frame_end) begin
      done_d = 1'b1;
    end else if (wr_ucon && wdata[1]) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    bus.Device_Read_Data = '0;
    if (bus.Device_Read) begin
      case (word)
        AddrTh:      bus.Device_Read_Data = th_q;
        AddrTl:      bus.Device_Read_Data = tl_q;
        AddrTcon:    bus.Device_Read_Data = {29'd0, tcon_q};
        AddrLed:     bus.Device_Read_Data = {24'd0, leds_q};
        AddrDigi:    bus.Device_Read_Data = {20'd0, digi_q};
        AddrSystick: bus.Device_Read_Data = systick_q;
        AddrUcon:    bus.Device_Read_Data = {30'd0, done_q, busy};
        default:     bus.Device_Read_Data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_responder.sv
// Directed bench for peripheral_bus_responder with a short UART bit time.
module tb_peripheral_bus_responder;

  localparam logic [31:0] ATh   = 32'h4000_0000;
  localparam logic [31:0] ATl   = 32'h4000_0004;
  localparam logic [31:0] ATcon = 32'h4000_0008;
  localparam logic [31:0] ALed  = 32'h4000_000C;
  localparam logic [31:0] ADigi = 32'h4000_0010;
  localparam logic [31:0] ASys  = 32'h4000_0014;
  localparam logic [31:0] ATxd  = 32'h4000_0018;
  localparam logic [31:0] AUcon = 32'h4000_001C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        uart_tx, irq;
  int          passed = 0;
  int          failed = 0;
  int          total = 0;
  int unsigned cyc = 0;

  peripheral_bus_responder_if bus ();

  peripheral_bus_responder #(.CLKS_PER_BIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .leds    (leds),
    .digi    (digi),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Rising edges since reset was last released; the expected SYSTICK value.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Device_Write      = 1'b1;
    bus.MemBus_Address    = addr;
    bus.MemBus_Write_Data = data;
    @(posedge clk);
    #1;
    bus.Device_Write = 1'b0;
  endtask

  // Samples on the falling edge of the current cycle, returns just after the next rising edge.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.Device_Read    = 1'b1;
    bus.MemBus_Address = addr;
    @(negedge clk);
    chk(tag, bus.Device_Read_Data, exp);
    @(posedge clk);
    #1;
    bus.Device_Read = 1'b0;
  endtask

  // pat[k] is the expected line level during bit slot k (start, d0..d7, stop).
  task automatic frame(input logic [7:0] d, input logic [9:0] pat, input bit inject);
    wr(ATxd, {24'd0, d});
    for (int c = 0; c < 40; c++) begin
      if (inject && c == 10) begin
        bus.Device_Write      = 1'b1;
        bus.MemBus_Write_Data = 32'h0000_003C;
      end
      bus.Device_Read    = 1'b1;
      bus.MemBus_Address = inject && c == 10 ? ATxd : AUcon;
      @(negedge clk);
      chk("uart_tx_bit", {31'd0, uart_tx}, {31'd0, pat[c/4]});
      if (!(inject && c == 10)) chk("uart_busy", bus.Device_Read_Data, 32'h1);
      @(posedge clk);
      #1;
      bus.Device_Write = 1'b0;
      bus.Device_Read  = 1'b0;
    end
    chk("uart_tx_idle", {31'd0, uart_tx}, 32'h1);
    rd("uart_con_done", AUcon, 32'h2);
  endtask

  initial begin
    bus.Device_Read       = 1'b0;
    bus.Device_Write      = 1'b0;
    bus.MemBus_Address    = '0;
    bus.MemBus_Write_Data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_uart_tx", {31'd0, uart_tx}, 32'h1);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rd("rst_th", ATh, 32'h0);
    rd("rst_tl", ATl, 32'h0);
    rd("rst_tcon", ATcon, 32'h0);
    rd("rst_led", ALed, 32'h0);
    rd("rst_digi", ADigi, 32'h0);
    rd("rst_systick", ASys, 32'd5);
    rd("rst_txd", ATxd, 32'h0);
    rd("rst_ucon", AUcon, 32'h0);
    rd("rst_unmapped", 32'h4000_0040, 32'h0);

    // Timer overflow and reload
    wr(ATh, 32'h1234_5678);
    wr(ATl, 32'hFFFF_FFFE);
    wr(ATcon, 32'h3);
    @(posedge clk);
    #1;
    rd("tl_first_edge", ATl, 32'hFFFF_FFFF);
    rd("tl_reload", ATl, 32'h1234_5678);
    rd("tcon_int_set", ATcon, 32'h7);
    chk("irq_set", {31'd0, irq}, 32'h1);
    wr(ATcon, 32'h3);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    rd("tl_counting", ATl, 32'h1234_567B);

    // Overflow coinciding with a TCON write of 0x3
    wr(ATcon, 32'h0);
    wr(ATl, 32'hFFFF_FFFF);
    wr(ATcon, 32'h3);
    wr(ATcon, 32'h3);
    chk("irq_race", {31'd0, irq}, 32'h1);
    rd("tcon_race", ATcon, 32'h7);
    wr(ATcon, 32'h0);
    chk("irq_off", {31'd0, irq}, 32'h0);

    // LED / DIGI / SYSTICK
    wr(ALed, 32'hFFFF_FF5A);
    wr(ADigi, 32'h0000_F3C7);
    chk("leds_pin", {24'd0, leds}, 32'h5A);
    chk("digi_pin", {20'd0, digi}, 32'h3C7);
    rd("led_rd", ALed, 32'h5A);
    rd("digi_rd", ADigi, 32'h3C7);
    rd("systick_pre", ASys, cyc);
    wr(ASys, 32'h0);
    rd("systick_ro", ASys, cyc);
    wr(32'h4000_000E, 32'h33);
    chk("led_alias_pin", {24'd0, leds}, 32'h33);
    rd("led_alias_rd", ALed, 32'h33);
    // Same-cycle read and write returns the old value
    bus.Device_Write      = 1'b1;
    bus.MemBus_Write_Data = 32'h77;
    rd("rw_same_cycle", ALed, 32'h33);
    bus.Device_Write = 1'b0;
    chk("rw_led_after", {24'd0, leds}, 32'h77);

    // UART frame of 0xA5 with an ignored mid-frame write of 0x3C
    frame(8'hA5, 10'b1_1010_0101_0, 1'b1);
    wr(AUcon, 32'h2);
    rd("uart_done_clr", AUcon, 32'h0);

    // Reset during DATA aborts the frame
    wr(ATxd, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("uart_data_low", {31'd0, uart_tx}, 32'h0);
    reset              = 1'b1;
    bus.Device_Read    = 1'b1;
    bus.MemBus_Address = AUcon;
    #1;
    chk("abort_tx_high", {31'd0, uart_tx}, 32'h1);
    chk("abort_not_busy", bus.Device_Read_Data, 32'h0);
    chk("abort_leds", {24'd0, leds}, 32'h0);
    bus.Device_Read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame(8'h55, 10'b1_0101_0101_0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
